alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/fwd_mux.sv | 32 +++
 rtl/alu_issue.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the issue stage.
//   - ALU operation codes driven on aluop
//   - opclass encodings presented by decode
//   - decode_op(): maps opclass/funct fields to an ALU op and an illegal flag
package cpu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  typedef enum logic [1:0] {
    OPC_MEM    = 2'b00,
    OPC_BRANCH = 2'b01,
    OPC_ARITH  = 2'b10,
    OPC_AUIPC  = 2'b11
  } opclass_e;

  typedef struct packed {
    logic [3:0] aluop;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode_op(input opclass_e   opc,
                                     input logic [2:0] funct3,
                                     input logic       funct7_30,
                                     input logic       alusrc);
    dec_t d;
    d.aluop   = ALU_ADD;
    d.illegal = 1'b0;
    case (opc)
      OPC_MEM:    d.aluop = ALU_ADD;
      OPC_BRANCH: d.aluop = ALU_SUB;
      OPC_AUIPC:  d.aluop = ALU_ADD;
      OPC_ARITH: begin
        case (funct3)
          // funct7[30] only means SUB for the register form; ADDI ignores it
          3'b000:  d.aluop = (funct7_30 && !alusrc) ? ALU_SUB : ALU_ADD;
          3'b111:  d.aluop = ALU_AND;
          3'b110:  d.aluop = ALU_OR;
          default: begin
            d.aluop   = ALU_ILL;
            d.illegal = 1'b1;
          end
        endcase
      end
      default: d.aluop = ALU_ADD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register.
//   rs          : source register index of the held instruction
//   stored      : value captured from the register file (or last forward)
//   exmem_*     : EX/MEM producer (highest priority)
//   memwb_*     : MEM/WB producer
//   value       : resolved operand; x0 always reads as zero
module fwd_mux #(
  parameter int XLEN = 64
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] stored,
  input  logic            exmem_wen,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            memwb_wen,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] value
);

  always_comb begin
    value = stored;
    if (rs == 5'd0) begin
      value = '0;
    end else if (exmem_wen && (exmem_rd == rs)) begin
      value = exmem_data;
    end else if (memwb_wen && (memwb_rd == rs)) begin
      value = memwb_data;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: a single-entry pipeline register between decode and the
// ALU. Decodes the ALU op at capture, resolves operands through forwarding
// every cycle, and keeps stored source data refreshed while stalled so a
// producer that retires during the stall is not lost.
//   in_valid/in_ready   : decode-side handshake (in_ready = !out_valid || out_ready)
//   in_*                : instruction fields and register-file reads
//   flush               : drop the held entry and any same-cycle capture
//   exmem_*, memwb_*    : forwarding sources
//   out_valid/out_ready : ALU-side handshake
//   op1, op2, aluop     : ALU operands and operation
//   out_rd, out_regwrite, out_store_data, out_illegal : passed-through results
//   stall_cnt           : saturating count of stalled cycles
module alu_issue
  import cpu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_alusrc,
  input  logic [1:0]      in_opclass,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_30,
  input  logic            in_regwrite,
  input  logic            flush,
  input  logic            exmem_wen,
  input  logic            memwb_wen,
  input  logic [4:0]      exmem_rd,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic [XLEN-1:0] memwb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [3:0]      aluop,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic [XLEN-1:0] out_store_data,
  output logic            out_illegal,
  output logic [CNTW-1:0] stall_cnt
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  logic            vld_p1;
  logic [3:0]      aluop_p1;
  logic            illegal_p1;
  logic            regwrite_p1;
  logic [4:0]      rd_p1;
  logic [4:0]      rs1_p1;
  logic [4:0]      rs2_p1;
  logic            use_pc_p1;
  logic            use_imm_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] imm_p1;
  logic [XLEN-1:0] rs1_data_p1;
  logic [XLEN-1:0] rs2_data_p1;
  logic [CNTW-1:0] stall_p1;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  dec_t            dec_p0;
  logic            capture;
  logic            hold;

  assign in_ready = !vld_p1 || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign hold     = vld_p1 && !out_ready && !flush;
  assign dec_p0   = decode_op(opclass_e'(in_opclass), in_funct3, in_funct7_30, in_alusrc);

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs(rs1_p1), .stored(rs1_data_p1),
    .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .value(rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs(rs2_p1), .stored(rs2_data_p1),
    .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .value(rs2_fwd)
  );

  // ---- stage p0 -> p1: capture register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      aluop_p1    <= ALU_AND;
      illegal_p1  <= 1'b0;
      regwrite_p1 <= 1'b0;
      rd_p1       <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      use_pc_p1   <= 1'b0;
      use_imm_p1  <= 1'b0;
      pc_p1       <= '0;
      imm_p1      <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      stall_p1    <= '0;
    end else begin
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (capture) begin
        vld_p1 <= 1'b1;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end

      if (capture) begin
        aluop_p1    <= dec_p0.aluop;
        illegal_p1  <= dec_p0.illegal;
        regwrite_p1 <= in_regwrite;
        rd_p1       <= in_rd;
        rs1_p1      <= in_rs1;
        rs2_p1      <= in_rs2;
        use_pc_p1   <= (in_opclass == OPC_AUIPC);
        // auipc always adds the immediate, whatever alusrc says
        use_imm_p1  <= in_alusrc || (in_opclass == OPC_AUIPC);
        pc_p1       <= in_pc;
        imm_p1      <= in_imm;
        rs1_data_p1 <= in_rs1_data;
        rs2_data_p1 <= in_rs2_data;
      end else if (hold) begin
        // fold any forward seen this cycle into the stored copy
        rs1_data_p1 <= rs1_fwd;
        rs2_data_p1 <= rs2_fwd;
      end

      if (vld_p1 && !out_ready) begin
        stall_p1 <= sat_inc(stall_p1);
      end
    end
  end

  // ---- stage p1: operand select ----
  assign out_valid      = vld_p1;
  assign aluop          = aluop_p1;
  assign out_illegal    = illegal_p1;
  assign out_regwrite   = regwrite_p1;
  assign out_rd         = rd_p1;
  assign op1            = use_pc_p1 ? pc_p1 : rs1_fwd;
  assign op2            = use_imm_p1 ? imm_p1 : rs2_fwd;
  assign out_store_data = rs2_fwd;
  assign stall_cnt      = stall_p1;

endmodule
